// File: rtl/alu_op_sequencer_if.sv
// Command, direct-load, ALU and response signals of the ALU operand sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_op_sequencer_if #(
  parameter int AW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic          cmd_use_imm;
  logic [31:0]   cmd_imm;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [3:0]    alu_control;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [31:0]   alu_c;
  logic          alu_zero;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_zero;
  logic [AW-1:0] rsp_rd;
  logic          rsp_illegal;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  ld_en, ld_addr, ld_data,
    input  alu_c, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_control, alu_a, alu_b,
    output rsp_valid, rsp_data, rsp_zero, rsp_rd, rsp_illegal
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output ld_en, ld_addr, ld_data,
    output alu_c, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_control, alu_a, alu_b,
    input  rsp_valid, rsp_data, rsp_zero, rsp_rd, rsp_illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand/control stage in front of a 32-bit ALU: register file, one command per
// handshake, IDLE -> EXEC -> RESP, result written back and returned as a response.
module alu_op_sequencer #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [3:0]    op_q,      op_d;
  logic [AW-1:0] rd_q,      rd_d;
  logic [AW-1:0] rs1_q,     rs1_d;
  logic [AW-1:0] rs2_q,     rs2_d;
  logic          use_imm_q, use_imm_d;
  logic [31:0]   imm_q,     imm_d;
  logic [31:0]   regs_q [NREGS];
  logic [31:0]   regs_d [NREGS];

  logic [31:0]   rsp_data_q,    rsp_data_d;
  logic          rsp_zero_q,    rsp_zero_d;
  logic [AW-1:0] rsp_rd_q,      rsp_rd_d;
  logic          rsp_illegal_q, rsp_illegal_d;

  logic [31:0]   opnd_a;
  logic [31:0]   opnd_b;
  logic          op_illegal;

  // Codes 8..15 are exactly those with the top bit of the 4-bit op set.
  assign op_illegal = op_q[3];

  // Combinational register reads; register 0 is forced to zero.
  always_comb begin
    opnd_a = 32'd0;
    opnd_b = 32'd0;
    if (rs1_q != {AW{1'b0}}) begin
      opnd_a = regs_q[rs1_q];
    end else begin
      opnd_a = 32'd0;
    end
    if (use_imm_q) begin
      opnd_b = imm_q;
    end else if (rs2_q != {AW{1'b0}}) begin
      opnd_b = regs_q[rs2_q];
    end else begin
      opnd_b = 32'd0;
    end
  end

  // ALU drive: operands only during EXEC, zero otherwise.
  always_comb begin
    bus.alu_control = 4'd0;
    bus.alu_a       = 32'd0;
    bus.alu_b       = 32'd0;
    if (state_q == ST_EXEC) begin
      bus.alu_control = op_q;
      bus.alu_a       = opnd_a;
      bus.alu_b       = opnd_b;
    end else begin
      bus.alu_control = 4'd0;
      bus.alu_a       = 32'd0;
      bus.alu_b       = 32'd0;
    end
  end

  assign bus.cmd_ready   = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_illegal = rsp_illegal_q;

  // Next-state, command latch, response capture and register-file update.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    use_imm_d     = use_imm_q;
    imm_d         = imm_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_illegal_d = rsp_illegal_q;
    regs_d        = regs_q;

    // Direct load is applied first so an EXEC writeback to the same register overrides it.
    if (bus.ld_en && (bus.ld_addr != {AW{1'b0}})) begin
      regs_d[bus.ld_addr] = bus.ld_data;
    end else begin
      regs_d[0] = 32'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          rd_d      = bus.cmd_rd;
          rs1_d     = bus.cmd_rs1;
          rs2_d     = bus.cmd_rs2;
          use_imm_d = bus.cmd_use_imm;
          imm_d     = bus.cmd_imm;
          state_d   = ST_EXEC;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_rd_d      = rd_q;
        rsp_illegal_d = op_illegal;
        if (op_illegal) begin
          rsp_data_d = 32'd0;
          rsp_zero_d = 1'b1;
        end else begin
          rsp_data_d = bus.alu_c;
          rsp_zero_d = bus.alu_zero;
          if (rd_q != {AW{1'b0}}) begin
            regs_d[rd_q] = bus.alu_c;
          end else begin
            regs_d[0] = 32'd0;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= 4'd0;
      rd_q          <= {AW{1'b0}};
      rs1_q         <= {AW{1'b0}};
      rs2_q         <= {AW{1'b0}};
      use_imm_q     <= 1'b0;
      imm_q         <= 32'd0;
      rsp_data_q    <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_rd_q      <= {AW{1'b0}};
      rsp_illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      use_imm_q     <= use_imm_d;
      imm_q         <= imm_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_illegal_q <= rsp_illegal_d;
      regs_q        <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, register-file model
// with load/writeback ordering, directed scenarios plus randomized commands.
module tb_alu_op_sequencer;
  localparam int AW    = 4;
  localparam int NREGS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.AW(AW)) bus ();

  alu_op_sequencer #(.NREGS(NREGS), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model [NREGS];

  logic [31:0] exp_a, exp_b, exp_res;
  logic        exp_zero, exp_ill;

  logic        obs_ready, obs_rv_exec, obs_rv, obs_rv_after, obs_ready_after, obs_resp_alu_zero;
  logic [3:0]  obs_ctl;
  logic [31:0] obs_a, obs_b, obs_data;
  logic        obs_zero, obs_ill;
  logic [AW-1:0] obs_rd;

  // Reference ALU; unused codes give a non-zero pattern so suppression is visible.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a ^ b;
      4'd4:    return a << sh;
      4'd5:    return a >> sh;
      4'd6:    return a - b;
      4'd7:    return $unsigned($signed(a) >>> sh);
      default: return 32'hBAD0_0001 ^ a;
    endcase
  endfunction

  assign bus.alu_c    = ref_alu(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_c == 32'd0);

  // Expected operands/result from pre-command contents, then loads, then writeback.
  task automatic predict(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic use_imm, input logic [31:0] imm,
                         input logic ld_x, input logic [AW-1:0] ld_a, input logic [31:0] ld_d);
    exp_a   = model[rs1];
    exp_b   = use_imm ? imm : model[rs2];
    exp_ill = (op > 4'd7);
    exp_res = exp_ill ? 32'd0 : ref_alu(op, exp_a, exp_b);
    exp_zero = exp_ill ? 1'b1 : (exp_res == 32'd0);
    if (ld_x && ld_a != '0) model[ld_a] = ld_d;
    if (!exp_ill && rd != '0) model[rd] = exp_res;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(posedge clk); #1;
    bus.ld_en = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  // Issue one command from IDLE (called at posedge+1) and capture what the DUT shows.
  task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic use_imm, input logic [31:0] imm,
                         input int stall, input logic ld_x, input logic [AW-1:0] ld_a, input logic [31:0] ld_d);
    obs_ready = bus.cmd_ready;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1;
    bus.cmd_rs2 = rs2; bus.cmd_use_imm = use_imm; bus.cmd_imm = imm; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    obs_ctl = bus.alu_control; obs_a = bus.alu_a; obs_b = bus.alu_b; obs_rv_exec = bus.rsp_valid;
    if (ld_x) begin
      bus.ld_en = 1'b1; bus.ld_addr = ld_a; bus.ld_data = ld_d;
    end
    @(posedge clk); #1;
    bus.ld_en = 1'b0;
    obs_rv = bus.rsp_valid; obs_data = bus.rsp_data; obs_zero = bus.rsp_zero;
    obs_rd = bus.rsp_rd; obs_ill = bus.rsp_illegal;
    obs_resp_alu_zero = (bus.alu_control == 4'd0) && (bus.alu_a == 32'd0) && (bus.alu_b == 32'd0);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    obs_rv_after = bus.rsp_valid; obs_ready_after = bus.cmd_ready;
  endtask

  task automatic read_reg(input logic [AW-1:0] r, output logic [31:0] val);
    run_cmd(4'd1, '0, r, '0, 1'b1, 32'd0, 0, 1'b0, '0, 32'd0);
    val = obs_data;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.cmd_use_imm = 1'b0; bus.cmd_imm = 32'd0; bus.ld_en = 1'b0; bus.ld_addr = '0;
    bus.ld_data = 32'd0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_hs ready=%b valid=%b required 0 0", bus.cmd_ready, bus.rsp_valid);
    end
    tests_run++;
    if ({bus.rsp_data, bus.rsp_zero, bus.rsp_rd, bus.rsp_illegal} !== '0) begin
      tests_failed++; $display("FAIL reset_rsp data=%h zero=%b rd=%0d ill=%b required all 0",
                               bus.rsp_data, bus.rsp_zero, bus.rsp_rd, bus.rsp_illegal);
    end
    tests_run++;
    if ({bus.alu_control, bus.alu_a, bus.alu_b} !== '0) begin
      tests_failed++; $display("FAIL reset_alu ctl=%h a=%h b=%h required 0", bus.alu_control, bus.alu_a, bus.alu_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release_ready got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic_add();
    logic [31:0] v;
    do_load(4'd1, 32'h0000_0005);
    do_load(4'd2, 32'h0000_0007);
    predict(4'd2, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cmd(4'd2, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 0, 1'b0, '0, 32'd0);
    tests_run++;
    if (obs_a !== 32'd5 || obs_b !== 32'd7 || obs_ctl !== 4'd2) begin
      tests_failed++; $display("FAIL add_exec a=%h b=%h ctl=%h required 5 7 2", obs_a, obs_b, obs_ctl);
    end
    tests_run++;
    if (obs_rv_exec !== 1'b0 || obs_rv !== 1'b1) begin
      tests_failed++; $display("FAIL add_latency exec_valid=%b resp_valid=%b required 0 1", obs_rv_exec, obs_rv);
    end
    tests_run++;
    if (obs_data !== 32'h0000_000C || obs_zero !== 1'b0 || obs_rd !== 4'd3 || obs_ill !== 1'b0) begin
      tests_failed++; $display("FAIL add_rsp data=%h zero=%b rd=%0d ill=%b required 0000000c 0 3 0",
                               obs_data, obs_zero, obs_rd, obs_ill);
    end
    tests_run++;
    if (obs_resp_alu_zero !== 1'b1) begin
      tests_failed++; $display("FAIL add_alu_idle got %b required 1 (ALU bus zero outside EXEC)", obs_resp_alu_zero);
    end
    read_reg(4'd3, v);
    tests_run++;
    if (v !== 32'h0000_000C) begin
      tests_failed++; $display("FAIL add_wb r3=%h required 0000000c", v);
    end
  endtask

  task automatic test_sub_backpressure();
    do_load(4'd1, 32'h1234_5678);
    do_load(4'd2, 32'h1234_5678);
    predict(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd6; bus.cmd_rd = 4'd4; bus.cmd_rs1 = 4'd1;
    bus.cmd_rs2 = 4'd2; bus.cmd_use_imm = 1'b0; bus.cmd_imm = 32'd0; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.cmd_ready !== 1'b0) begin
        tests_failed++; $display("FAIL sub_stall cycle=%0d valid=%b data=%h zero=%b ready=%b required 1 0 1 0",
                                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.cmd_ready);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL sub_release valid=%b ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_imm_r0();
    logic [31:0] v;
    do_load(4'd1, 32'h8000_0000);
    do_load(4'd0, 32'hFFFF_FFFF);
    predict(4'd7, 4'd0, 4'd1, 4'd9, 1'b1, 32'd4, 1'b0, '0, 32'd0);
    run_cmd(4'd7, 4'd0, 4'd1, 4'd9, 1'b1, 32'd4, 0, 1'b0, '0, 32'd0);
    tests_run++;
    if (obs_b !== 32'd4 || obs_a !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL imm_operands a=%h b=%h required 80000000 4", obs_a, obs_b);
    end
    tests_run++;
    if (obs_data !== 32'hF800_0000 || obs_zero !== 1'b0) begin
      tests_failed++; $display("FAIL imm_sra data=%h zero=%b required f8000000 0", obs_data, obs_zero);
    end
    read_reg(4'd0, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++; $display("FAIL r0_reads_zero got %h required 0", v);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    do_load(4'd5, 32'hDEAD_BEEF);
    predict(4'd9, 4'd5, 4'd5, 4'd1, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cmd(4'd9, 4'd5, 4'd5, 4'd1, 1'b0, 32'd0, 0, 1'b0, '0, 32'd0);
    tests_run++;
    if (obs_ctl !== 4'd9 || obs_a !== 32'hDEAD_BEEF || obs_b !== exp_b) begin
      tests_failed++; $display("FAIL ill_drive ctl=%h a=%h b=%h required 9 deadbeef %h", obs_ctl, obs_a, obs_b, exp_b);
    end
    tests_run++;
    if (obs_ill !== 1'b1 || obs_data !== 32'd0 || obs_zero !== 1'b1) begin
      tests_failed++; $display("FAIL ill_rsp ill=%b data=%h zero=%b required 1 0 1", obs_ill, obs_data, obs_zero);
    end
    read_reg(4'd5, v);
    tests_run++;
    if (v !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL ill_no_wb r5=%h required deadbeef", v);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    do_load(4'd1, 32'h0000_0050);
    predict(4'd2, 4'd3, 4'd1, 4'd0, 1'b1, 32'd5, 1'b1, 4'd3, 32'hAAAA_AAAA);
    run_cmd(4'd2, 4'd3, 4'd1, 4'd0, 1'b1, 32'd5, 0, 1'b1, 4'd3, 32'hAAAA_AAAA);
    read_reg(4'd3, v);
    tests_run++;
    if (v !== 32'h0000_0055) begin
      tests_failed++; $display("FAIL collision_wb_wins r3=%h required 00000055", v);
    end
    predict(4'd2, 4'd6, 4'd1, 4'd0, 1'b1, 32'd5, 1'b1, 4'd1, 32'h0000_1000);
    run_cmd(4'd2, 4'd6, 4'd1, 4'd0, 1'b1, 32'd5, 0, 1'b1, 4'd1, 32'h0000_1000);
    tests_run++;
    if (obs_data !== 32'h0000_0055) begin
      tests_failed++; $display("FAIL load_during_exec_read data=%h required 00000055", obs_data);
    end
    read_reg(4'd1, v);
    tests_run++;
    if (v !== 32'h0000_1000) begin
      tests_failed++; $display("FAIL load_during_exec_lands r1=%h required 00001000", v);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      predict(4'd3, 4'd8, 4'd8, 4'd0, 1'b1, 32'h0F0F_0000 + k, 1'b0, '0, 32'd0);
      run_cmd(4'd3, 4'd8, 4'd8, 4'd0, 1'b1, 32'h0F0F_0000 + k, 0, 1'b0, '0, 32'd0);
      tests_run++;
      if (obs_ready !== 1'b1 || obs_rv_after !== 1'b0 || obs_ready_after !== 1'b1 || obs_data !== exp_res) begin
        tests_failed++; $display("FAIL b2b k=%0d ready=%b valid_after=%b ready_after=%b data=%h required 1 0 1 %h",
                                 k, obs_ready, obs_rv_after, obs_ready_after, obs_data, exp_res);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [AW-1:0] rd, rs1, rs2, la; logic ui, lx; logic [31:0] imm, ld;
    logic [31:0] v; int st;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) do_load(AW'($urandom_range(0, NREGS - 1)), $urandom);
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rd  = AW'($urandom_range(0, NREGS - 1));
      rs1 = AW'($urandom_range(0, NREGS - 1));
      rs2 = AW'($urandom_range(0, NREGS - 1));
      ui  = 1'($urandom_range(0, 1));
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      st  = $urandom_range(0, 2);
      lx  = ($urandom_range(0, 3) == 0);
      la  = ($urandom_range(0, 1) == 0) ? rd : rs1;
      ld  = $urandom;
      predict(op, rd, rs1, rs2, ui, imm, lx, la, ld);
      run_cmd(op, rd, rs1, rs2, ui, imm, st, lx, la, ld);
      tests_run++;
      if (obs_ctl !== op || obs_a !== exp_a || obs_b !== exp_b || obs_data !== exp_res ||
          obs_zero !== exp_zero || obs_ill !== exp_ill || obs_rd !== rd || obs_rv !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand n=%0d op=%0d got ctl=%h a=%h b=%h data=%h z=%b ill=%b rd=%0d required %h %h %h %h %b %b %0d",
                 n, op, obs_ctl, obs_a, obs_b, obs_data, obs_zero, obs_ill, obs_rd,
                 op, exp_a, exp_b, exp_res, exp_zero, exp_ill, rd);
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      read_reg(AW'(r), v);
      tests_run++;
      if (v !== model[r]) begin
        tests_failed++; $display("FAIL rand_regfile r%0d=%h required %h", r, v, model[r]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] v;
    do_load(4'd7, 32'h1357_9BDF);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'd2; bus.cmd_rd = 4'd9; bus.cmd_rs1 = 4'd7;
    bus.cmd_rs2 = 4'd7; bus.cmd_use_imm = 1'b0; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.rsp_data !== 32'd0) begin
      tests_failed++; $display("FAIL midreset_async valid=%b ready=%b data=%h required 0 0 0",
                               bus.rsp_valid, bus.cmd_ready, bus.rsp_data);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_release ready=%b valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    for (int r = 0; r < NREGS; r++) begin
      read_reg(AW'(r), v);
      tests_run++;
      if (v !== 32'd0) begin
        tests_failed++; $display("FAIL midreset_regs r%0d=%h required 0", r, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_sub_backpressure();
    test_imm_r0();
    test_illegal();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Operand and control stage directly upstream of the 32-bit ALU (ops 0-7: AND, OR, ADD, XOR, SLL, SRL, SUB, SRA; combinational `c`/`zero`).
- Holds a small register file and accepts one command per valid/ready handshake.
- Reads the operands, drives the ALU, captures `c`/`zero`, writes the result back, and returns a response through a second valid/ready handshake.

Parameters:
- NREGS, 16, number of 32-bit registers. Must be a power of two. Register 0 always reads 0.
- AW, 4, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  ALU control code.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source register for ALU input a.
- cmd_rs2  in  AW  source register for ALU input b.
- cmd_use_imm  in  1  when 1, b is cmd_imm instead of reg[rs2].
- cmd_imm  in  32  immediate operand.
- ld_en  in  1  direct register load strobe.
- ld_addr  in  AW  direct load address.
- ld_data  in  32  direct load data.
- alu_control  out  4  to ALU control.
- alu_a  out  32  to ALU input a.
- alu_b  out  32  to ALU input b.
- alu_c  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  captured ALU result.
- rsp_zero  out  1  captured zero flag.
- rsp_rd  out  AW  destination of the response.
- rsp_illegal  out  1  cmd_op was 8..15.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers = 0.
  - rsp_valid, rsp_data, rsp_zero, rsp_rd, rsp_illegal = 0.
  - Latched command fields = 0.
  - cmd_ready = 0 while rst_n is low.
  - alu_control, alu_a, alu_b = 0.
- Reset mid-operation abandons the command: no writeback and no response.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch op, rd, rs1, rs2, use_imm, imm, then go to EXEC.
- State EXEC (exactly one cycle):
  - cmd_ready = 0.
  - alu_control = latched op.
  - alu_a = reg[rs1].
  - alu_b = use_imm ? imm : reg[rs2].
  - Register reads are combinational; reg 0 reads 0.
  - At the end of the cycle:
    - rsp_data <= alu_c; rsp_zero <= alu_zero; rsp_rd <= rd; rsp_illegal <= (op > 7).
    - If op <= 7 and rd != 0, reg[rd] <= alu_c.
    - Go to RESP.
- Illegal op (8..15) in EXEC:
  - alu_control and alu_a/alu_b are still driven as normal.
  - No register write.
  - rsp_data <= 0 and rsp_zero <= 1, regardless of alu_c.
- State RESP:
  - rsp_valid = 1; cmd_ready = 0.
  - rsp_* fields stay stable until the handshake completes.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Outside EXEC: alu_control, alu_a, alu_b = 0.
- Latency:
  - Command accepted at edge N: EXEC during cycle N to N+1, rsp_valid high from edge N+1.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP) with rsp_ready held at 1.
- Direct load:
  - ld_en writes reg[ld_addr] <= ld_data at any edge, in any state.
  - ld_addr = 0 is ignored.
  - A load during EXEC to a register being read is not seen by that op, because reads take the pre-edge value.
- Simultaneous EXEC writeback and ld_en to the same address: the writeback wins.
- No read-after-write hazard between commands: writeback completes before the next EXEC.
- Shift ops pass the full 32-bit b to the ALU. The sequencer does not mask it; shift-amount semantics belong to the ALU.

Test Plan:
1. Basic ADD:
   - Stimulus: ld r1=0x0000_0005, ld r2=0x0000_0007; cmd op=2, rs1=1, rs2=2, rd=3.
   - Required: alu_a=5 and alu_b=7 in EXEC; rsp_valid at accept+1 with rsp_data=0x0C and rsp_zero=0; r3 then reads 0x0C.
2. SUB giving zero, with backpressure:
   - Stimulus: r1=r2=0x1234_5678; op=6, rd=4; hold rsp_ready=0 for 5 cycles.
   - Required: rsp_valid stays 1 with rsp_data=0 and rsp_zero=1 stable; cmd_ready=0 throughout; IDLE follows the rsp_ready pulse.
3. Immediate and r0 destination:
   - Stimulus: r1=0x8000_0000; op=7, use_imm=1, imm=4, rd=0.
   - Required: alu_b=4; rsp_data equals alu_c (0xF800_0000 from a correct SRA); r0 still reads 0.
4. Illegal op:
   - Stimulus: op=9, rd=5, with r5=0xDEAD_BEEF beforehand.
   - Required: rsp_illegal=1, rsp_data=0, rsp_zero=1; r5 unchanged at 0xDEAD_BEEF.
5. Writeback vs load collision:
   - Stimulus: ld_en with ld_addr=3, ld_data=0xAAAA_AAAA in the same cycle as EXEC writing rd=3 with result 0x55.
   - Required: r3=0x55.
6. Reset mid-operation:
   - Stimulus: assert rst_n=0 during RESP.
   - Required: rsp_valid=0 immediately (asynchronous); all registers read 0; cmd_ready=1 on the first cycle after release.
